bf_stage_ctrl: RTL

- Sequencer for the add/sub butterfly PE (6-cycle fixed latency, 12-bit operands) in the 512-point mixed NTT.
- Walks all butterfly stages over an N-coefficient dual-port memory.
- Issues u/v read addresses, then issues write-back addresses delayed to match memory-read plus PE latency.
- Drains the pipeline between stages so each stage reads only fully written results.

---
 rtl/bf_stage_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bf_stage_ctrl.sv
// bf_stage_ctrl: stage and address sequencer for the add/sub butterfly PE.
// It walks every butterfly stage over an N-coefficient dual-port memory.
// Read addresses are issued one butterfly per cycle. The write-back addresses
// are produced by delaying the read addresses through the read and PE latency.
// Between stages the sequencer drains, so a stage never reads a stale operand.
// Optional macro BF_ISSUE_STALL_EN adds the issue_stall input, which holds issue in RUN.
module bf_stage_ctrl #(
  parameter int unsigned N          = 512,
  parameter int unsigned LOGN       = 9,
  parameter int unsigned NUM_STAGES = 9,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PE_LAT     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode_intt,
`ifdef BF_ISSUE_STALL_EN
  input  logic            issue_stall,
`endif
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_u,
  output logic [LOGN-1:0] rd_addr_v,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_u,
  output logic [LOGN-1:0] wr_addr_v,
  output logic            pe_sel_ntt,
  output logic [3:0]      stage
);

  localparam int unsigned     L        = RD_LAT + PE_LAT;
  localparam logic [LOGN-2:0] K_LAST   = '1;
  localparam logic [LOGN-1:0] LEN_FWD  = LOGN'(N / 2);
  localparam logic [LOGN-1:0] LEN_INV  = LOGN'(1);
  localparam logic [3:0]      LAST_STG = 4'(NUM_STAGES - 1);
  localparam logic [L-1:0]    MSB_ONLY = L'(1) << (L - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state, state_next;
  logic            hold;
  logic            issue;
  logic            stage_adv;
  logic            drain_last;
  logic [LOGN-2:0] k;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] k_ext;
  logic [LOGN-1:0] addr_u;
  logic [LOGN-1:0] addr_v;
  logic [3:0]      stage_q;
  logic            fwd;
  logic [L-1:0]    v_pipe;
  logic [LOGN-1:0] wu_pipe [L];
  logic [LOGN-1:0] wv_pipe [L];

`ifdef BF_ISSUE_STALL_EN
  assign hold = issue_stall;
`else
  assign hold = 1'b0;
`endif

  // The final write of a stage is leaving the delay line this cycle, and nothing else is in flight.
  assign drain_last = (v_pipe == MSB_ONLY);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode plus the issue, stage-advance and status strobes.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    stage_adv  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!hold) begin
          issue = 1'b1;
          if (k == K_LAST) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_last) begin
          if (stage_q == LAST_STG) begin
            state_next = FIN;
          end else begin
            stage_adv  = 1'b1;
            state_next = RUN;
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Butterfly counter, stage index, span and latched direction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k       <= '0;
      stage_q <= '0;
      len     <= '0;
      fwd     <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        fwd     <= ~mode_intt;
        k       <= '0;
        stage_q <= '0;
        len     <= mode_intt ? LEN_INV : LEN_FWD;
      end
      // k wraps to zero naturally on the last butterfly of a stage.
      if (issue) k <= k + 1'b1;
      if (stage_adv) begin
        stage_q <= stage_q + 1'b1;
        len     <= fwd ? (len >> 1) : (len << 1);
      end
    end
  end

  // len is one-hot, so (k/len)*2*len + k%len is k with its high part shifted up one place.
  always_comb begin
    k_ext  = {1'b0, k};
    mask   = len - 1'b1;
    addr_u = ((k_ext & ~mask) << 1) | (k_ext & mask);
    addr_v = addr_u | len;
  end

  // Delay line carrying issued reads forward to become write-backs L cycles later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_pipe <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        wu_pipe[i] <= '0;
        wv_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0]  <= rd_en;
      wu_pipe[0] <= rd_addr_u;
      wv_pipe[0] <= rd_addr_v;
      for (int unsigned i = 1; i < L; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        wu_pipe[i] <= wu_pipe[i-1];
        wv_pipe[i] <= wv_pipe[i-1];
      end
    end
  end

  assign rd_en      = issue;
  assign rd_addr_u  = issue ? addr_u : '0;
  assign rd_addr_v  = issue ? addr_v : '0;
  assign wr_en      = v_pipe[L-1];
  assign wr_addr_u  = wu_pipe[L-1];
  assign wr_addr_v  = wv_pipe[L-1];
  assign pe_sel_ntt = fwd;
  assign stage      = stage_q;

endmodule
